// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encodings,
// default sizing and a helper for the watchdog counter width.
package rr_arb_pkg;

    localparam int DEFAULT_ARB_WIDTH   = 16;
    localparam int DEFAULT_ARB_TIMEOUT = 1024;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Watchdog counter width; at least one bit so a disabled watchdog
    // still yields a legal vector.
    function automatic int cntWidth(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arb_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any bit is set,
// the one-hot lowest set bit and its binary index.
module prio_enc #(
    parameter int WIDTH    = 16,
    parameter int WIDTH_L2 = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]    pe_vec_in,
    output logic                pe_found,
    output logic [WIDTH-1:0]    pe_vec_out,
    output logic [WIDTH_L2-1:0] pe_bin_out
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        pe_found   = 1'b0;
        pe_vec_out = '0;
        pe_bin_out = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pe_vec_in[i]) begin
                pe_found   = 1'b1;
                pe_vec_out = '0;
                pe_vec_out[i] = 1'b1;
                pe_bin_out = WIDTH_L2'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: picks the next requester above the last grantee,
// holds the grant until ack or watchdog expiry, then rotates.
module rr_arb
    import rr_arb_pkg::*;
#(
    parameter int ARB_WIDTH    = DEFAULT_ARB_WIDTH,
    parameter int ARB_WIDTH_L2 = $clog2(ARB_WIDTH),
    parameter int ARB_TIMEOUT  = DEFAULT_ARB_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ARB_WIDTH-1:0]    arb_req,
    input  logic                    arb_ack,
    output logic                    arb_gnt_vld,
    output logic [ARB_WIDTH-1:0]    arb_gnt_vec,
    output logic [ARB_WIDTH_L2-1:0] arb_gnt_bin,
    output logic                    arb_timeout
);

    localparam int                CNT_W   = cntWidth(ARB_TIMEOUT);
    localparam bit                WDOG_EN = (ARB_TIMEOUT > 0);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_EXP = WDOG_EN ? CNT_W'(ARB_TIMEOUT - 1) : '0;

    arb_state_e              state_q;
    logic [ARB_WIDTH_L2-1:0] lastIdx_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    gntVld_q;
    logic [ARB_WIDTH-1:0]    gntVec_q;
    logic [ARB_WIDTH_L2-1:0] gntBin_q;
    logic                    timeout_q;

    logic [ARB_WIDTH-1:0]    masked;
    logic                    maskedFound;
    logic [ARB_WIDTH-1:0]    maskedVec;
    logic [ARB_WIDTH_L2-1:0] maskedBin;
    logic                    rawFound;
    logic [ARB_WIDTH-1:0]    rawVec;
    logic [ARB_WIDTH_L2-1:0] rawBin;
    logic [ARB_WIDTH-1:0]    winVec_d;
    logic [ARB_WIDTH_L2-1:0] winBin_d;

    // Drop every request at or below the last grantee so the search
    // starts just above it.
    always_comb begin
        masked = '0;
        for (int i = 0; i < ARB_WIDTH; i++) begin
            masked[i] = arb_req[i] && (i > int'(lastIdx_q));
        end
    end

    prio_enc #(.WIDTH(ARB_WIDTH), .WIDTH_L2(ARB_WIDTH_L2)) uMaskedEnc (
        .pe_vec_in  (masked),
        .pe_found   (maskedFound),
        .pe_vec_out (maskedVec),
        .pe_bin_out (maskedBin)
    );

    prio_enc #(.WIDTH(ARB_WIDTH), .WIDTH_L2(ARB_WIDTH_L2)) uRawEnc (
        .pe_vec_in  (arb_req),
        .pe_found   (rawFound),
        .pe_vec_out (rawVec),
        .pe_bin_out (rawBin)
    );

    // Fall back to the raw requests when nothing sits above the pointer.
    always_comb begin
        winVec_d = maskedFound ? maskedVec : rawVec;
        winBin_d = maskedFound ? maskedBin : rawBin;
    end

    // Grant FSM with registered outputs, pointer and saturating watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            lastIdx_q <= ARB_WIDTH_L2'(ARB_WIDTH - 1);
            cnt_q     <= '0;
            gntVld_q  <= 1'b0;
            gntVec_q  <= '0;
            gntBin_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (rawFound) begin
                        state_q   <= ARB_GRANT;
                        gntVld_q  <= 1'b1;
                        gntVec_q  <= winVec_d;
                        gntBin_q  <= winBin_d;
                        lastIdx_q <= winBin_d;
                        cnt_q     <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (arb_ack) begin
                        state_q  <= ARB_IDLE;
                        gntVld_q <= 1'b0;
                        gntVec_q <= '0;
                        gntBin_q <= '0;
                    end else if (WDOG_EN && (cnt_q == CNT_EXP)) begin
                        state_q   <= ARB_IDLE;
                        gntVld_q  <= 1'b0;
                        gntVec_q  <= '0;
                        gntBin_q  <= '0;
                        timeout_q <= 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign arb_gnt_vld = gntVld_q;
    assign arb_gnt_vec = gntVec_q;
    assign arb_gnt_bin = gntBin_q;
    assign arb_timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb.sv
// Bench for rr_arb with a short watchdog: directed scenarios plus random
// traffic, checked cycle by cycle against a rotating-scan reference model.
module tb_rr_arb;

    localparam int W = 16;
    localparam int T = 8;

    logic          clk;
    logic          rst;
    logic [W-1:0]  arb_req;
    logic          arb_ack;
    logic          arb_gnt_vld;
    logic [W-1:0]  arb_gnt_vec;
    logic [3:0]    arb_gnt_bin;
    logic          arb_timeout;

    rr_arb #(.ARB_WIDTH(W), .ARB_WIDTH_L2(4), .ARB_TIMEOUT(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .arb_req     (arb_req),
        .arb_ack     (arb_ack),
        .arb_gnt_vld (arb_gnt_vld),
        .arb_gnt_vec (arb_gnt_vec),
        .arb_gnt_bin (arb_gnt_bin),
        .arb_timeout (arb_timeout)
    );

    typedef struct {
        int          cyc;
        logic        vld;
        logic [W-1:0] vec;
        logic [3:0]  bin;
        logic        to;
    } exp_t;

    exp_t expQ[$];
    int   gntLog[$];
    bit   logEn = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    // Reference model: who holds the grant and for how many visible cycles.
    bit   mBusy = 1'b0;
    int   mOwner = 0;
    int   mHeld = 0;
    int   mLast = W - 1;
    int   mGrants = 0;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to tag expectations.
    always @(posedge clk) cyc++;

    // Monitor: compare due expectations after the edge settles and log new grants.
    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            exp_t e;
            e = expQ.pop_front();
            checks++;
            if (arb_gnt_vld !== e.vld || arb_gnt_vec !== e.vec ||
                arb_gnt_bin !== e.bin || arb_timeout !== e.to) begin
                $display("[TB] FAIL grant@cyc%0d: got vld=%b vec=%h bin=%0d to=%b, want vld=%b vec=%h bin=%0d to=%b",
                         e.cyc, arb_gnt_vld, arb_gnt_vec, arb_gnt_bin, arb_timeout,
                         e.vld, e.vec, e.bin, e.to);
            end else begin
                passes++;
            end
            if (logEn && e.vld && e.to == 1'b0 && arb_gnt_vld === 1'b1 && mLogRise(e)) begin
                gntLog.push_back(int'(arb_gnt_bin));
            end
        end
    end

    logic prevExpVld = 1'b0;
    function automatic bit mLogRise(input exp_t e);
        bit rise;
        rise = e.vld && !prevExpVld;
        return rise;
    endfunction
    always @(negedge clk) #1 prevExpVld = arb_gnt_vld;

    // One cycle of stimulus: drive inputs, advance the model, queue the result.
    task automatic applyStimulus(input logic [W-1:0] req, input logic ack, input logic r);
        exp_t e;
        bit   to;
        arb_req = req;
        arb_ack = ack;
        rst     = r;
        to = 1'b0;
        if (r) begin
            mBusy = 1'b0;
            mLast = W - 1;
        end else if (!mBusy) begin
            if (req != '0) begin
                for (int j = 1; j <= W; j++) begin
                    int idx;
                    idx = (mLast + j) % W;
                    if (req[idx]) begin
                        mOwner = idx;
                        break;
                    end
                end
                mBusy = 1'b1;
                mHeld = 1;
                mLast = mOwner;
                mGrants++;
            end
        end else if (ack) begin
            mBusy = 1'b0;
        end else if (mHeld == T) begin
            mBusy = 1'b0;
            to = 1'b1;
        end else begin
            mHeld++;
        end
        e.cyc = cyc + 1;
        e.vld = mBusy;
        e.vec = mBusy ? (W'(1) << mOwner) : '0;
        e.bin = mBusy ? 4'(mOwner) : 4'd0;
        e.to  = to;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Compare the logged grant order against a fixed index sequence.
    task automatic checkOutput(input string name, input int want[]);
        for (int i = 0; i < want.size(); i++) begin
            checks++;
            if (i >= gntLog.size()) begin
                $display("[TB] FAIL %s[%0d]: got no grant, want index %0d", name, i, want[i]);
            end else if (gntLog[i] != want[i]) begin
                $display("[TB] FAIL %s[%0d]: got index %0d, want index %0d", name, i, gntLog[i], want[i]);
            end else begin
                passes++;
            end
        end
    endtask

    task automatic startLog();
        gntLog.delete();
        logEn = 1'b1;
    endtask

    initial begin
        int base;
        rst = 1'b1;
        arb_req = '0;
        arb_ack = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with all requests, then first grant goes to index 0.
        repeat (3) applyStimulus(16'hFFFF, 1'b0, 1'b1);
        repeat (3) applyStimulus(16'hFFFF, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 1'b1, 1'b0);
        repeat (2) applyStimulus(16'h0000, 1'b0, 1'b0);

        // Single requester, ack three cycles into the grant.
        repeat (2) applyStimulus(16'h0000, 1'b0, 1'b1);
        repeat (4) applyStimulus(16'h0001, 1'b0, 1'b0);
        applyStimulus(16'h0001, 1'b1, 1'b0);
        repeat (2) applyStimulus(16'h0000, 1'b0, 1'b0);

        // Rotation over a sparse request set.
        repeat (2) applyStimulus(16'h0000, 1'b0, 1'b1);
        startLog();
        repeat (20) applyStimulus(16'h8421, mBusy && mHeld == 2, 1'b0);
        logEn = 1'b0;
        repeat (2) applyStimulus(16'h0000, 1'b0, 1'b1);
        checkOutput("rotation", '{0, 5, 10, 15, 0});

        // Wrap-around from index 15.
        startLog();
        base = mGrants;
        repeat (12) applyStimulus((mGrants == base) ? 16'h8000 : 16'h0006, mBusy && mHeld == 2, 1'b0);
        logEn = 1'b0;
        repeat (2) applyStimulus(16'h0000, 1'b0, 1'b1);
        checkOutput("wrap", '{15, 1, 2});

        // Watchdog expiry with the request still held.
        startLog();
        repeat (22) applyStimulus(16'h0010, 1'b0, 1'b0);
        logEn = 1'b0;
        repeat (2) applyStimulus(16'h0000, 1'b0, 1'b1);
        checkOutput("timeout", '{4, 4});

        // Ack landing on the expiry cycle, then acks while idle.
        repeat (12) applyStimulus(16'h0010, mBusy && mHeld == T, 1'b0);
        repeat (3) applyStimulus(16'h0000, 1'b1, 1'b0);
        repeat (3) applyStimulus(16'h0020, 1'b0, 1'b0);
        applyStimulus(16'h0000, 1'b1, 1'b0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 500; n++) begin
            logic [W-1:0] req;
            req = ($urandom_range(0, 3) == 0) ? '0 : (W'($urandom) & W'($urandom));
            applyStimulus(req, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        end

        repeat (2) applyStimulus(16'h0000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
        end else begin
            passes++;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
